key_gesture: RTL and testbench

Classifies debounced key activity into short-press, double-click, long-press and auto-repeat events. It sits directly downstream of the key debouncer and consumes that stage's one-cycle press/release flags and its level output. It emits one-cycle event flags plus an encoded event bus for the control logic.

---
 rtl/key_gesture_pkg.sv | 38 +++
 rtl/key_gesture_if.sv | 36 +++
 rtl/key_gesture.sv | 109 ++++++++++
 tb/tb_key_gesture.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/key_gesture_pkg.sv
// key_gesture_pkg
//   Shared definitions for the key gesture classifier: FSM state encodings,
//   Event_Code values and the internal event flag bundle.
package key_gesture_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_PRESSED      = 3'd1;
  localparam logic [2:0] ST_LONG_HOLD    = 3'd2;
  localparam logic [2:0] ST_WAIT_SECOND  = 3'd3;
  localparam logic [2:0] ST_SECOND_PRESS = 3'd4;

  typedef logic [1:0] ev_code_t;

  // Event_Code values
  localparam ev_code_t EV_SHORT  = 2'd0;
  localparam ev_code_t EV_DOUBLE = 2'd1;
  localparam ev_code_t EV_LONG   = 2'd2;
  localparam ev_code_t EV_REPEAT = 2'd3;

  // One bit per event kind; at most one bit is set in any cycle.
  typedef struct packed {
    logic short_f;
    logic double_f;
    logic long_f;
    logic repeat_f;
  } ev_flags_t;

  function automatic ev_code_t ev_encode(input ev_flags_t f);
    ev_code_t c;
    c = EV_SHORT;
    if (f.double_f) c = EV_DOUBLE;
    if (f.long_f)   c = EV_LONG;
    if (f.repeat_f) c = EV_REPEAT;
    return c;
  endfunction

endpackage

// File: rtl/key_gesture_if.sv
// key_gesture_if
//   Bundles the debounced key inputs and the classified event outputs.
//   master : debouncer / stimulus side (drives key signals, sees events)
//   slave  : key_gesture side (sees key signals, drives events)
//   Key_P_Flag / Key_R_Flag : one-cycle debounced press / release pulses
//   Key_State               : debounced level, 1 = released, 0 = pressed
//   *_Flag, Event_Valid     : one-cycle event pulses
//   Event_Code              : encoded event, held between events
//   Busy                    : gesture in progress
interface key_gesture_if;
  import key_gesture_pkg::*;

  logic     Key_P_Flag;
  logic     Key_R_Flag;
  logic     Key_State;
  logic     Short_Flag;
  logic     Double_Flag;
  logic     Long_Flag;
  logic     Repeat_Flag;
  logic     Event_Valid;
  ev_code_t Event_Code;
  logic     Busy;

  modport master (
    output Key_P_Flag, Key_R_Flag, Key_State,
    input  Short_Flag, Double_Flag, Long_Flag, Repeat_Flag,
           Event_Valid, Event_Code, Busy
  );

  modport slave (
    input  Key_P_Flag, Key_R_Flag, Key_State,
    output Short_Flag, Double_Flag, Long_Flag, Repeat_Flag,
           Event_Valid, Event_Code, Busy
  );

endinterface

// File: rtl/key_gesture.sv
// key_gesture
//   Classifies debounced key activity into short-press, double-click,
//   long-press and auto-repeat events.
//   Ports:
//     Clk     : system clock, rising edge
//     Reset_n : asynchronous active-low reset
//     kif     : key_gesture_if.slave (key inputs in, event outputs out)
//   Parameters (cycles, thresholds compared with equality):
//     LONG_CNT : hold time before a long press
//     DBL_CNT  : post-release window for a second press
//     REP_CNT  : auto-repeat period while a long press is held
module key_gesture
  import key_gesture_pkg::*;
#(
  parameter int unsigned LONG_CNT = 50_000_000 - 1,
  parameter int unsigned DBL_CNT  = 15_000_000 - 1,
  parameter int unsigned REP_CNT  = 10_000_000 - 1
) (
  input logic          Clk,
  input logic          Reset_n,
  key_gesture_if.slave kif
);

  logic [2:0]  state, state_nxt;
  logic [31:0] cnt;
  logic        cnt_clr;
  logic        rel;
  ev_flags_t   ev_nxt, ev_q;
  logic        valid_q;
  ev_code_t    code_q;
  logic        busy_q;

  // A high level without the release pulse is still a release: it keeps the
  // FSM from sticking in a "pressed" state if a pulse is ever missed.
  assign rel = kif.Key_R_Flag | kif.Key_State;

  // State register, counter and registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      ev_q    <= '0;
      valid_q <= 1'b0;
      code_q  <= EV_SHORT;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_clr ? 32'd0 : cnt + 32'd1;
      ev_q    <= ev_nxt;
      valid_q <= |ev_nxt;
      if (|ev_nxt) code_q <= ev_encode(ev_nxt);
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  // Next state. Release beats a coincident long/repeat threshold and a
  // second press beats a coincident short timeout.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (kif.Key_P_Flag) state_nxt = ST_PRESSED;
      ST_PRESSED:
        if (rel)                  state_nxt = ST_WAIT_SECOND;
        else if (cnt == LONG_CNT) state_nxt = ST_LONG_HOLD;
      ST_LONG_HOLD:
        if (rel) state_nxt = ST_IDLE;
      ST_WAIT_SECOND:
        if (kif.Key_P_Flag)      state_nxt = ST_SECOND_PRESS;
        else if (cnt == DBL_CNT) state_nxt = ST_IDLE;
      ST_SECOND_PRESS:
        if (rel) state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  // Event decode, registered into the output flags next edge
  always_comb begin
    ev_nxt = '0;
    case (state)
      ST_PRESSED:
        if (!rel && cnt == LONG_CNT) ev_nxt.long_f = 1'b1;
      ST_LONG_HOLD:
        if (!rel && cnt == REP_CNT) ev_nxt.repeat_f = 1'b1;
      ST_WAIT_SECOND:
        if (!kif.Key_P_Flag && cnt == DBL_CNT) ev_nxt.short_f = 1'b1;
      ST_SECOND_PRESS:
        if (rel) ev_nxt.double_f = 1'b1;
      default: ;
    endcase
  end

  // Counter restarts on every state change, stays at zero where it has no
  // meaning, and restarts each repeat period in LONG_HOLD.
  always_comb begin
    cnt_clr = (state_nxt != state) || (state == ST_IDLE) ||
              (state == ST_SECOND_PRESS) || ev_nxt.repeat_f;
  end

  assign kif.Short_Flag  = ev_q.short_f;
  assign kif.Double_Flag = ev_q.double_f;
  assign kif.Long_Flag   = ev_q.long_f;
  assign kif.Repeat_Flag = ev_q.repeat_f;
  assign kif.Event_Valid = valid_q;
  assign kif.Event_Code  = code_q;
  assign kif.Busy        = busy_q;

endmodule

// File: tb/tb_key_gesture.sv
// tb_key_gesture
//   Randomized + directed gestures; expected event lists (edge index, code)
//   are computed arithmetically from the gesture timing and compared with the
//   events observed on the DUT outputs.
module tb_key_gesture;
  import key_gesture_pkg::*;

  localparam int L = 99;
  localparam int D = 29;
  localparam int R = 19;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  key_gesture_if kif();

  key_gesture #(.LONG_CNT(L), .DBL_CNT(D), .REP_CNT(R)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .kif     (kif)
  );

  typedef struct {
    int e;
    int code;
  } ev_t;

  int   checks = 0;
  int   failures = 0;
  int   edge_cnt = 0;
  bit   mon_en = 1'b0;
  int   last_code = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Records every event with the index of the edge that registered it.
  always @(negedge Clk) begin : mon
    int n, c;
    if (Reset_n && mon_en) begin
      n = int'(kif.Short_Flag) + int'(kif.Double_Flag) +
          int'(kif.Long_Flag) + int'(kif.Repeat_Flag);
      if (n != 0 || kif.Event_Valid) begin
        c = kif.Double_Flag ? 1 : kif.Long_Flag ? 2 : kif.Repeat_Flag ? 3 : 0;
        chk("onehot", n, 1);
        chk("valid", kif.Event_Valid, 1);
        chk("code_vs_flag", kif.Event_Code, c);
        obs_q.push_back('{edge_cnt, c});
      end
    end
  end

  // Inputs applied at a negedge are sampled by edge t.
  task automatic step(input bit p, input bit r, input bit s, output int t);
    @(negedge Clk);
    t = edge_cnt + 1;
    kif.Key_P_Flag = p;
    kif.Key_R_Flag = r;
    kif.Key_State  = s;
  endtask

  // Gesture rules expressed as event times relative to the press edge t0.
  task automatic model(input int t0, input int h1, input bit sec, input int g, input int h2);
    int r;
    r = t0 + h1;
    if (h1 >= L + 2) begin
      exp_q.push_back('{t0 + L + 1, 2});
      for (int e = t0 + L + 1 + (R + 1); e < r; e += R + 1)
        exp_q.push_back('{e, 3});
    end else if (sec) begin
      exp_q.push_back('{r + g + h2, 1});
    end else begin
      exp_q.push_back('{r + D + 1, 0});
    end
  endtask

  task automatic compare(input string name);
    int n;
    chk({name, ":n_events"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, ":ev_edge"}, obs_q[i].e, exp_q[i].e);
      chk({name, ":ev_code"}, obs_q[i].code, exp_q[i].code);
    end
    if (exp_q.size() > 0) last_code = exp_q[exp_q.size()-1].code;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_gesture(input string name, input int h1, input bit sec,
                             input int g, input int h2, input bit lvl);
    int t0, t, r;
    step(1'b1, 1'b0, 1'b0, t0);
    @(posedge Clk); #1;
    chk({name, ":busy"}, kif.Busy, 1);
    repeat (h1 - 1) step(1'b0, 1'b0, 1'b0, t);
    step(1'b0, !lvl, 1'b1, r);
    if (sec) begin
      repeat (g - 1) step(1'b0, 1'b0, 1'b1, t);
      step(1'b1, 1'b0, 1'b0, t);
      repeat (h2 - 1) step(1'b0, 1'b0, 1'b0, t);
      step(1'b0, !lvl, 1'b1, t);
    end
    repeat (D + 8) step(1'b0, 1'b0, 1'b1, t);
    model(t0, h1, sec, g, h2);
    compare(name);
    chk({name, ":idle"}, kif.Busy, 0);
    chk({name, ":code_hold"}, kif.Event_Code, last_code);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, ":short"},  kif.Short_Flag, 0);
    chk({name, ":double"}, kif.Double_Flag, 0);
    chk({name, ":long"},   kif.Long_Flag, 0);
    chk({name, ":repeat"}, kif.Repeat_Flag, 0);
    chk({name, ":valid"},  kif.Event_Valid, 0);
    chk({name, ":code"},   kif.Event_Code, 0);
    chk({name, ":busy"},   kif.Busy, 0);
  endtask

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, h1, g, h2;
    bit sec, lvl;
    kif.Key_P_Flag = 1'b0;
    kif.Key_R_Flag = 1'b0;
    kif.Key_State  = 1'b1;
    repeat (3) @(posedge Clk);
    #1 check_all_zero("reset");
    @(negedge Clk);
    Reset_n = 1'b1;
    mon_en  = 1'b1;

    // Release pulses in IDLE are ignored
    repeat (3) begin
      step(1'b0, 1'b1, 1'b1, t);
      step(1'b0, 1'b0, 1'b1, t);
    end
    repeat (5) step(1'b0, 1'b0, 1'b1, t);
    compare("idle_release");
    chk("idle_release:busy", kif.Busy, 0);

    run_gesture("short",        10,    1'b0, 0,     0, 1'b0);
    run_gesture("double",       10,    1'b1, 15,    5, 1'b0);
    run_gesture("long_rep",     161,   1'b0, 0,     0, 1'b0);
    run_gesture("rel_at_long",  L + 1, 1'b0, 0,     0, 1'b0);
    run_gesture("press_at_to",  10,    1'b1, D + 1, 5, 1'b0);
    run_gesture("long_2nd",     5,     1'b1, 3,   140, 1'b0);
    run_gesture("lvl_release",  7,     1'b0, 0,     0, 1'b1);

    // Reset while in LONG_HOLD drops the gesture
    step(1'b1, 1'b0, 1'b0, t0);
    repeat (L + R + 6) step(1'b0, 1'b0, 1'b0, t);
    @(posedge Clk); #2;
    Reset_n = 1'b0;
    #1 check_all_zero("rst_mid");
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (5) step(1'b0, 1'b0, 1'b0, t);
    step(1'b0, 1'b1, 1'b1, t);
    repeat (D + 8) step(1'b0, 1'b0, 1'b1, t);
    exp_q.push_back('{t0 + L + 1, 2});
    exp_q.push_back('{t0 + L + 1 + R + 1, 3});
    compare("rst_mid");
    last_code = 0;
    chk("rst_mid:code_after", kif.Event_Code, 0);
    chk("rst_mid:busy_after", kif.Busy, 0);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0:       h1 = $urandom_range(1, 20);
        1:       h1 = $urandom_range(L - 3, L + 4);
        2:       h1 = $urandom_range(L + 2, L + 80);
        default: h1 = $urandom_range(1, L);
      endcase
      sec = ($urandom_range(0, 1) == 1) && (h1 <= L + 1);
      g   = ($urandom_range(0, 2) == 0) ? D + 1 : $urandom_range(1, D + 1);
      h2  = $urandom_range(1, 150);
      lvl = ($urandom_range(0, 3) == 0);
      run_gesture("rand", h1, sec, g, h2, lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
